// File: rtl/fp_arb_pkg.sv
// fp_arb_pkg: shared types and constants for the shared FP unit arbiter.
package fp_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} fparb_state_t;
    localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr_i (mod NUM_REQ).
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [IW-1:0]      grant_o,
    output logic               any_o
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IW:0]          sum;
    assign dbl = {req_i, req_i} >> ptr_i;
    assign rot = dbl[NUM_REQ-1:0];
    // Scan downward so the lowest rotated offset wins.
    always_comb begin
        grant_o = '0;
        any_o = 1'b0;
        sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) begin
                sum = {1'b0, ptr_i} + (IW+1)'(k);
                grant_o = sum >= (IW+1)'(NUM_REQ) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
                any_o = 1'b1;
            end
    end
endmodule

// File: rtl/fp_unit_arbiter.sv
// fp_unit_arbiter: round-robin sharing of one multi-cycle FP unit among NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining FPARB_TIMEOUT_EN.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [DATA_W-1:0]    req_a [NUM_REQ],
    input  logic [DATA_W-1:0]    req_b [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [DATA_W-1:0]    resp_data,
    output logic                 fu_ready_in,
    output logic [DATA_W-1:0]    fu_a,
    output logic [DATA_W-1:0]    fu_b,
    input  logic                 fu_ready_out,
    input  logic [DATA_W-1:0]    fu_out,
    output logic                 busy,
    output logic [31:0]          op_count,
    output logic                 fu_timeout
);
    localparam int IW = $clog2(NUM_REQ);
    fparb_state_t state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d, ptr_q, ptr_d, pick;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [31:0] op_count_q, op_count_d;
    logic any, tmo_hit;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req_i(req_valid), .ptr_i(ptr_q), .grant_o(pick), .any_o(any)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            gnt_q <= '0;
            ptr_q <= '0;
            a_q <= '0;
            b_q <= '0;
            res_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
            a_q <= a_d;
            b_q <= b_d;
            res_q <= res_d;
            op_count_q <= op_count_d;
        end

    always_comb begin
        state_d = state_q;
        gnt_d = gnt_q;
        ptr_d = ptr_q;
        a_d = a_q;
        b_d = b_q;
        res_d = res_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE:
                if (any) begin
                    state_d = ISSUE;
                    gnt_d = pick;
                    a_d = req_a[pick];
                    b_d = req_b[pick];
                end
            ISSUE: state_d = WAIT;
            WAIT:
                if (fu_ready_out) begin
                    res_d = fu_out;
                    state_d = RESPOND;
                end else if (tmo_hit) begin
                    res_d = DATA_W'(FP64_QNAN);
                    state_d = RESPOND;
                end
            RESPOND: begin
                op_count_d = op_count_q + 32'd1;
                ptr_d = gnt_q == IW'(NUM_REQ - 1) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FPARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic fu_timeout_q, fu_timeout_d;
    // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
    assign tmo_hit = state_q == WAIT && !fu_ready_out && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign tmo_d = state_q == WAIT ? tmo_q + 1'b1 : '0;
    assign fu_timeout_d = fu_timeout_q | tmo_hit;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            tmo_q <= '0;
            fu_timeout_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            fu_timeout_q <= fu_timeout_d;
        end
    assign fu_timeout = fu_timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign fu_timeout = 1'b0;
`endif

    assign req_ready = (state_q == IDLE && any) ? NUM_REQ'(1) << pick : '0;
    assign resp_valid = state_q == RESPOND ? NUM_REQ'(1) << gnt_q : '0;
    assign resp_data = res_q;
    assign fu_ready_in = state_q == ISSUE;
    assign fu_a = a_q;
    assign fu_b = b_q;
    assign busy = state_q != IDLE;
    assign op_count = op_count_q;
endmodule

// File: doc/fp_unit_arbiter.md
Name: fp_unit_arbiter

Overview:
- Shares one multi-cycle floating-point unit (multiplier, adder or divider with the ready_in/ready_out pulse handshake) between NUM_REQ requesters, e.g. per-node pagerank lanes.
- Uses round-robin arbitration and runs one operation at a time.
- Latches operands, issues them to the unit, waits for the result, and returns it to the granted requester.
- Sits between the pagerank compute FSMs and a single shared dawson_* unit, replacing per-node FP unit instances.

Parameters:
- NUM_REQ, 4, number of requesters (2..32).
- DATA_W, 64, operand/result width (IEEE-754 double).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with FPARB_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  [NUM_REQ]  requester i holds an operation pending; held until accepted.
- req_a  in  DATA_W x NUM_REQ  operand a per requester.
- req_b  in  DATA_W x NUM_REQ  operand b per requester.
- req_ready  out  [NUM_REQ]  one-cycle accept pulse to the granted requester.
- resp_valid  out  [NUM_REQ]  one-cycle result pulse to the granted requester.
- resp_data  out  DATA_W  result; valid while any resp_valid is high.
- fu_ready_in  out  1  one-cycle issue pulse to the FP unit.
- fu_a  out  DATA_W  latched operand a to the FP unit.
- fu_b  out  DATA_W  latched operand b to the FP unit.
- fu_ready_out  in  1  FP unit result-valid pulse.
- fu_out  in  DATA_W  FP unit result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  32  completed operations; wraps 0xFFFFFFFF -> 0.
- fu_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE, rr pointer = 0.
  - All outputs 0, op_count 0, operand/result registers 0, fu_timeout 0.
  - Reset mid-operation abandons the op and issues no response. A late fu_ready_out arriving in IDLE is ignored.
- States:
  - IDLE:
    - If any req_valid: g = first i with req_valid[i], searching from the rr pointer upward mod NUM_REQ.
    - req_ready[g] = 1 combinationally in this cycle. Latch g, req_a[g], req_b[g]. Go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE: fu_ready_in = 1 for exactly this cycle, with fu_a/fu_b driven from latches. Go to WAIT.
  - WAIT:
    - On fu_ready_out: latch fu_out into the result register. Go to RESPOND.
    - fu_ready_out is sampled only in WAIT; a pulse in ISSUE is ignored (unit latency is at least 1).
  - RESPOND:
    - resp_valid[g] = 1 and resp_data = result register, for one cycle.
    - op_count += 1. rr pointer = (g+1) mod NUM_REQ. Go to IDLE.
- Timing:
  - Accept in cycle T, fu_ready_in at T+1.
  - Unit latency L means fu_ready_out at T+1+L, resp_valid at T+2+L.
  - Next accept no earlier than T+3+L.
- Boundary conditions:
  - req_valid deasserted before acceptance: no grant.
  - Requester i must not change req_a/req_b while req_valid[i] is high and unaccepted.
  - The granted requester may assert req_valid again in the RESPOND cycle; it is then the lowest priority in the next IDLE.
  - All requesters valid: grants in strict rotation g, g+1, ...
  - At most one req_ready bit and at most one resp_valid bit high per cycle.
  - fu_a/fu_b hold their last value outside ISSUE; fu_ready_in is 0 outside ISSUE.

Optional Feature:
- FPARB_TIMEOUT_EN defined:
  - A WAIT-cycle counter is cleared on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without fu_ready_out: set fu_timeout (sticky until reset) and load the result register with quiet NaN 0x7FF8000000000000. Go to RESPOND with the normal response; op_count increments.
- FPARB_TIMEOUT_EN undefined:
  - No counter; WAIT lasts indefinitely.
  - fu_timeout is tied 0 and the port remains present.

Decomposition:
- Package fp_arb_pkg:
  - state enum fparb_state_t {IDLE, ISSUE, WAIT, RESPOND}.
  - constant FP64_QNAN = 64'h7FF8000000000000.
- Sub-module rr_pick, purely combinational:
  - Inputs: req vector and pointer.
  - Outputs: grant index and any_valid.
  - Instantiated once; reusable by other shared-unit arbiters.

Test Plan:
- Single op, model multiplier L=4:
  - Stimulus: req_valid[2], a=0x3FF8000000000000 (1.5), b=0x4000000000000000 (2.0), accepted at T.
  - Response: req_ready[2] at T, fu_ready_in at T+1, resp_valid[2] at T+6, resp_data=0x4008000000000000 (3.0), op_count=1.
- All four requesters valid continuously, rr pointer 0:
  - Grant order 0,1,2,3,0.
  - Each resp_valid goes only to its own index, with result matching that requester's operands.
- Requester 1 re-requests in its RESPOND cycle while requester 3 is waiting:
  - Next grant is 3, then 1.
- Reset asserted during WAIT, then a late fu_ready_out pulse:
  - No resp_valid, busy=0, op_count=0, next request is served normally from pointer 0.
- With FPARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, unit never responds:
  - resp_valid after 16 WAIT cycles with resp_data=0x7FF8000000000000.
  - fu_timeout=1 and stays 1 across later successful ops.
- op_count preset by forcing to 0xFFFFFFFF, one op completes:
  - op_count = 0.
